// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared constants and helpers for the round-robin / select stream mux.
//   MODE_SEL : mode input value that routes the channel named by sel.
//   MODE_RR  : mode input value that rotates priority across channels.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Wrap a channel offset back into 0..n-1. The arbiter only ever passes
  // values below 2*n, so a plain modulo is enough.
  function automatic int ch_wrap(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Pure combinational rotating-priority search. Starting one past the
//   previous winner, it returns the first requesting channel, wrapping
//   modulo N_CH.
//   Ports:
//     req     [N_CH]  per-channel request
//     last    [SELW]  previous winner; the search starts at last+1
//     gnt_idx [SELW]  winning channel (0 when gnt_vld = 0)
//     gnt_vld         some channel was requesting
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    logic [SELW-1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Offset N_CH comes back around to last itself, so the previous
    // winner is still served when nobody else is asking.
    for (int k = 1; k <= N_CH; k++) begin
      cand = SELW'(ch_wrap(int'(last) + k, N_CH));
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-to-1 valid/ready stream multiplexer with a single registered
//   output stage. The channel is either the one named by sel (mode = 0) or
//   chosen by rotating priority (mode = 1).
//
//   Parameters: N_CH (2..16) channels, WIDTH (1..64) data bits per channel.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     mode       0 = select by sel, 1 = round-robin
//     sel        channel index used in select mode
//     in_data    N_CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//     in_valid   per-channel valid
//     in_ready   per-channel ready (at most one bit set)
//     out_data   registered data of the last accepted beat
//     out_valid  registered valid
//     out_ready  downstream ready
//     out_ch     channel that supplied out_data
//
//   Optional build macro STREAM_MUX_RR_LOCK_EN adds:
//     in_last    per-channel end-of-packet marker
//     out_last   registered alongside out_data
//   With it, once a channel sends a beat with in_last = 0, it keeps the
//   grant in both modes until its beat with in_last = 1 has been accepted.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 4,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch
`ifdef STREAM_MUX_RR_LOCK_EN
  ,
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last
`endif
);

  logic [SELW-1:0] last_grant;
  logic [SELW-1:0] rr_idx;
  logic            rr_vld;
  logic            sel_vld;
  logic [SELW-1:0] grant;
  logic            grant_valid;
  logic            load_en;
  logic            xfer;
  logic            lock_hold;
  logic [SELW-1:0] lock_ch;

  rr_arbiter #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .last    (last_grant),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Select-mode request check. Comparing against every legal index, rather
  // than indexing in_valid with sel, makes out-of-range sel values grant
  // nothing when N_CH is not a power of two.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SELW'(i) && in_valid[i]) sel_vld = 1'b1;
    end
  end

  // A locked packet takes priority over both modes. While the locked
  // channel is idle, nobody is granted, so the packet cannot be split.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (lock_hold) begin
      grant       = lock_ch;
      grant_valid = in_valid[lock_ch];
    end else if (mode == MODE_RR) begin
      grant       = rr_idx;
      grant_valid = rr_vld;
    end else begin
      grant       = sel;
      grant_valid = sel_vld;
    end
  end

  // The output register can take a new beat when it is empty or is being
  // drained on this edge. This still gives full throughput. in_ready reads
  // out_ready, but out_valid is only ever a flop output.
  assign load_en = !out_valid || out_ready;
  assign xfer    = grant_valid && load_en;

  // reset gates in_ready so that no channel sees a handshake while the
  // block is held in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = reset && xfer && (grant == SELW'(i));
    end
  end

  // last_grant resets to N_CH-1 so that channel 0 wins the first
  // round-robin search.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SELW'(N_CH - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_ch     <= grant;
      last_grant <= grant;
    end else if (load_en) begin
      // Drained with nothing to replace it: drop valid, keep data and
      // channel as they were.
      out_valid  <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_LOCK_EN
  logic locked;
  logic [SELW-1:0] locked_ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked    <= 1'b0;
      locked_ch <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      locked    <= !in_last[grant];
      locked_ch <= grant;
      out_last  <= in_last[grant];
    end
  end

  assign lock_hold = locked;
  assign lock_ch   = locked_ch;
`else
  assign lock_hold = 1'b0;
  assign lock_ch   = '0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int N_CH  = 4;
  localparam int WIDTH = 4;
  localparam int SELW  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  mode = 1'b0;
  logic [SELW-1:0]       sel = '0;
  logic [N_CH*WIDTH-1:0] in_data = 16'hDA73;
  logic [N_CH-1:0]       in_valid = '0;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [SELW-1:0]       out_ch;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic [N_CH-1:0]       in_last = '0;
  logic                  out_last;
`endif

  stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef STREAM_MUX_RR_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] data;
  } beat_t;

  beat_t q[$];
  beat_t mon_b;

  // The channel data pattern matches in_data = 16'hDA73.
  logic [3:0] chdat [4] = '{4'h3, 4'h7, 4'hA, 4'hD};

  typedef struct {
    logic [1:0] sel;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] ch;
    logic [3:0] data;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_beat(input int c);
    beat_t b;
    b.ch   = c[1:0];
    b.data = chdat[c];
    q.push_back(b);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Each negedge with out_valid && out_ready is exactly one output handshake
  // on the following rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch %0d, expected no beat", out_ch);
      end else begin
        mon_b = q.pop_front();
        chk("sb_ch", 32'(out_ch), 32'(mon_b.ch));
        chk("sb_data", 32'(out_data), 32'(mon_b.data));
      end
    end
  end

  initial begin
    vt[0] = '{2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2, 4'hA};
    vt[1] = '{2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0, 4'h3};
    vt[2] = '{2'd3, 4'b0111, 4'b0000, 1'b0, 2'd0, 4'h3};
    vt[3] = '{2'd1, 4'b0010, 4'b0010, 1'b1, 2'd1, 4'h7};
    vt[4] = '{2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3, 4'hD};
    vt[5] = '{2'd1, 4'b1101, 4'b0000, 1'b0, 2'd3, 4'hD};

    // Reset held with every channel valid.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);

    // Release into round-robin: 0,1,2,3,0,1,2,3 back to back.
    reset = 1'b1;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) expect_beat(i % 4);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rr_no_gap", 32'(out_valid), 1);
    end
    in_valid = '0;
    tick;

    // Select-mode table.
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel = vt[i].sel;
      in_valid = vt[i].vld;
      if (vt[i].ov) expect_beat(int'(vt[i].ch));
      #1;
      chk("sel_in_ready", 32'(in_ready), 32'(vt[i].rdy));
      tick;
      chk("sel_out_valid", 32'(out_valid), 32'(vt[i].ov));
      chk("sel_out_ch", 32'(out_ch), 32'(vt[i].ch));
      chk("sel_out_data", 32'(out_data), 32'(vt[i].data));
    end
    in_valid = '0;
    tick;

    // Backpressure: hold ch0's beat for 3 cycles, then continue.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    expect_beat(0);
    tick;
    chk("bp_first_ch", 32'(out_ch), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick;
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ch", 32'(out_ch), 0);
      chk("bp_hold_data", 32'(out_data), 32'h3);
    end
    out_ready = 1'b1;
    expect_beat(1); expect_beat(2); expect_beat(3);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_resume_valid", 32'(out_valid), 1);
    end
    in_valid = '0;
    tick;

    // Sparse: ch1 and ch3 alternate, then ch1 alone every cycle.
    in_valid = 4'b1010;
    expect_beat(1); expect_beat(3); expect_beat(1); expect_beat(3);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("sparse_valid", 32'(out_valid), 1);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) expect_beat(1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("sparse_ch1", 32'(out_ch), 1);
    end
    in_valid = '0;
    tick;

`ifdef STREAM_MUX_RR_LOCK_EN
    // The ch0 packet stays locked through sel changes; ch1 is served only
    // after in_last.
    mode = 1'b1; in_valid = 4'b0011; in_last = 4'b0000;
    expect_beat(0);
    tick;
    chk("lock_b0_ch", 32'(out_ch), 0);
    chk("lock_b0_last", 32'(out_last), 0);
    mode = 1'b0; sel = 2'd1;
    expect_beat(0);
    tick;
    chk("lock_b1_ch", 32'(out_ch), 0);
    chk("lock_b1_last", 32'(out_last), 0);
    sel = 2'd3; in_last = 4'b0001;
    expect_beat(0);
    tick;
    chk("lock_b2_ch", 32'(out_ch), 0);
    chk("lock_b2_last", 32'(out_last), 1);
    mode = 1'b1; in_last = 4'b0010;
    expect_beat(1);
    tick;
    chk("lock_b3_ch", 32'(out_ch), 1);
    chk("lock_b3_last", 32'(out_last), 1);
    in_valid = '0; in_last = '0;
    tick;
`endif

    // Asynchronous reset between clock edges while a beat is held.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    tick;
    chk("ar_pre_valid", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_data", 32'(out_data), 0);
    chk("ar_out_ch", 32'(out_ch), 0);
    chk("ar_in_ready", 32'(in_ready), 0);

    chk("sb_drain", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL provide parameter WIDTH, default 4: data bits per channel, legal range 1..64.
REQ-003 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide port mode, input, 1: 0 = select mode, 1 = round-robin mode.
REQ-006 SHALL provide port sel, input, SELW = $clog2(N_CH): channel index used in select mode.
REQ-007 SHALL provide port in_data, input, N_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL provide port in_valid, input, N_CH: per-channel valid.
REQ-009 SHALL provide port in_ready, output, N_CH: per-channel ready.
REQ-010 SHALL provide port out_data, output, WIDTH: registered output data.
REQ-011 SHALL provide port out_valid, output, 1: registered output valid.
REQ-012 SHALL provide port out_ready, input, 1: downstream ready.
REQ-013 SHALL provide port out_ch, output, SELW: index of the channel that supplied out_data.

Function
REQ-014 A transfer on any interface SHALL occur only on a clock edge where valid and ready are both 1.
REQ-015 load_en SHALL equal (!out_valid || out_ready), giving one output register stage, 1-cycle latency and full throughput.
REQ-016 Exactly one channel g SHALL be granted per cycle, or none; in_ready[i] SHALL be (i == g) && grant_valid && load_en, and 0 for all other channels.
REQ-017 Select mode: grant SHALL be sel when in_valid[sel] = 1, else none; sel values >= N_CH SHALL grant none.
REQ-018 Round-robin mode: grant SHALL go to the first channel with in_valid = 1, searching from last_grant+1 upward modulo N_CH.
REQ-019 last_grant SHALL update to g only on an input transfer, in either mode.
REQ-020 On an input transfer, out_data, out_ch and out_valid = 1 SHALL load on the same edge.
REQ-021 If load_en = 1 and there is no grant, out_valid SHALL clear to 0, and out_data and out_ch SHALL hold.
REQ-022 While out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid SHALL hold stable.
REQ-023 A change of mode or sel SHALL affect only the arbitration on that cycle and SHALL NOT disturb the output register.
REQ-024 All in_ready outputs SHALL be combinational in in_valid, mode, sel, out_valid, out_ready and state; no out_ready-to-out_valid combinational path SHALL exist.

Reset
REQ-025 While reset = 0, out_valid, out_data, out_ch and in_ready SHALL be 0 and last_grant SHALL be N_CH-1, so the first round-robin grant goes to channel 0.
REQ-026 Assertion of reset SHALL take effect immediately, mid-transfer or not; release SHALL be used synchronously to clk.

Configuration
REQ-027 Macro STREAM_MUX_RR_LOCK_EN, when defined, SHALL add ports in_last (input, N_CH) and out_last (output, 1, registered with out_data, reset 0).
REQ-028 With the macro, after a transfer with in_last = 0, grant SHALL stay locked to that channel in both modes, ignoring sel and rotation, until a transfer with in_last = 1.
REQ-029 Without the macro, in_last and out_last SHALL NOT exist and every beat SHALL be arbitrated independently.

Structure
REQ-030 Package stream_mux_pkg SHALL hold the mode constants MODE_SEL = 1'b0 and MODE_RR = 1'b1.
REQ-031 Rotating priority search SHALL be a sub-module rr_arbiter with inputs req[N_CH] and last[SELW], and outputs gnt_idx and gnt_vld.

Verification
REQ-032 Reset: hold reset = 0 with all in_valid = 1 -> out_valid = 0, in_ready = 0; release with mode = 1 -> first out_ch = 0.
REQ-033 Select mode: N_CH = 4, WIDTH = 4, sel = 2, in_data ch2 = 4'hA, all valid, out_ready = 1 -> out_data = 4'hA and out_ch = 2 one cycle later, only in_ready[2] high.
REQ-034 Round-robin: all four channels valid, out_ready = 1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no gap cycles.
REQ-035 Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> out_data and out_ch stable and in_ready all 0; on release, next beat follows without loss.
REQ-036 Sparse: only ch1 and ch3 valid, mode = 1 -> out_ch alternates 1,3,1,3; drop ch3 valid -> ch1 on every cycle.
REQ-037 With LOCK_EN: ch0 sends 3 beats with in_last = 0,0,1 while ch1 is valid -> out_ch = 0,0,0 then 1; toggling sel mid-packet has no effect.
